// File: rtl/insn_pkg.sv
// Shared instruction-set definitions: request kinds, opcodes, field positions
// and the kind-to-format mapping. The decode side imports the same package so
// opcode values live in exactly one place.
package insn_pkg;

  typedef enum logic [3:0] {
    KIND_ALU  = 4'd0,
    KIND_J    = 4'd1,
    KIND_BNE  = 4'd2,
    KIND_JAL  = 4'd3,
    KIND_JR   = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_BLT  = 4'd6,
    KIND_SW   = 4'd7,
    KIND_LW   = 4'd8,
    KIND_SETX = 4'd9,
    KIND_BEX  = 4'd10
  } insn_kind_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_JI,
    FMT_JII,
    FMT_BAD
  } insn_fmt_e;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int WORD_W    = 32;
  localparam int REG_W     = 5;
  localparam int IMM_W     = 17;
  localparam int TGT_W     = 27;
  localparam int OP_LSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_LSB    = 17;
  localparam int RT_LSB    = 12;
  localparam int SHAMT_LSB = 7;
  localparam int ALUOP_LSB = 2;

  // Encoding layout for a request kind; FMT_BAD marks the reserved kinds 11..15.
  function automatic insn_fmt_e fmt_of(input logic [3:0] kind);
    insn_fmt_e f;
    case (kind)
      KIND_ALU:                                      f = FMT_R;
      KIND_ADDI, KIND_SW, KIND_LW, KIND_BNE, KIND_BLT: f = FMT_I;
      KIND_J, KIND_JAL, KIND_SETX, KIND_BEX:         f = FMT_JI;
      KIND_JR:                                       f = FMT_JII;
      default:                                       f = FMT_BAD;
    endcase
    return f;
  endfunction

  // Opcode for a request kind; kinds 0..8 map straight through.
  function automatic logic [4:0] op_of(input logic [3:0] kind);
    logic [4:0] op;
    case (kind)
      KIND_ALU:  op = OP_ALU;
      KIND_J:    op = OP_J;
      KIND_BNE:  op = OP_BNE;
      KIND_JAL:  op = OP_JAL;
      KIND_JR:   op = OP_JR;
      KIND_ADDI: op = OP_ADDI;
      KIND_BLT:  op = OP_BLT;
      KIND_SW:   op = OP_SW;
      KIND_LW:   op = OP_LW;
      KIND_SETX: op = OP_SETX;
      KIND_BEX:  op = OP_BEX;
      default:   op = 5'd0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Request channel (symbolic instruction in) and imem write channel (ISA word
// out) of the instruction encoder. master = requester/imem side, slave = encoder.
interface insn_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [4:0]        in_aluop;
  logic [26:0]       in_imm;

  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm,
    output imem_ready,
    input  in_ready, imem_we, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm,
    input  imem_ready,
    output in_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/insn_fifo.sv
// Small synchronous FIFO holding encoded words between accept and imem write.
// DEPTH must be a power of two so the pointers wrap naturally.
module insn_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_d  = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents need no reset since empty gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/insn_encoder.sv
// Instruction encoder: turns symbolic requests into 32-bit ISA words, queues
// them and streams them into imem at an auto-incrementing address.
// Optional build macro INSN_ENC_IMM_CHECK_EN: I-type immediates that do not
// fit 17-bit signed are dropped and flagged on imm_range_err.
module insn_encoder
  import insn_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  insn_encoder_if.slave     bus,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] load_value,
  output logic              illegal_kind,
`ifdef INSN_ENC_IMM_CHECK_EN
  output logic              imm_range_err,
`endif
  output logic [15:0]       words_written
);
  insn_fmt_e         fmt;
  logic [WORD_W-1:0] enc_word;
  logic              accept;
  logic              push;
  logic              imm_bad;
  logic              done;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              ill_q, ill_d;
  logic [15:0]       ww_q, ww_d;

  assign fmt = fmt_of(bus.in_kind);

  // Encode the request fields into the ISA word according to its format.
  always_comb begin
    enc_word = '0;
    enc_word[OP_LSB +: REG_W] = op_of(bus.in_kind);
    case (fmt)
      FMT_R: begin
        enc_word[RD_LSB    +: REG_W] = bus.in_rd;
        enc_word[RS_LSB    +: REG_W] = bus.in_rs;
        enc_word[RT_LSB    +: REG_W] = bus.in_rt;
        enc_word[SHAMT_LSB +: REG_W] = bus.in_shamt;
        enc_word[ALUOP_LSB +: REG_W] = bus.in_aluop;
      end
      FMT_I: begin
        enc_word[RD_LSB +: REG_W] = bus.in_rd;
        enc_word[RS_LSB +: REG_W] = bus.in_rs;
        enc_word[0      +: IMM_W] = bus.in_imm[IMM_W-1:0];
      end
      FMT_JI:  enc_word[0 +: TGT_W] = bus.in_imm;
      FMT_JII: enc_word[RD_LSB +: REG_W] = bus.in_rd;
      default: enc_word = '0;
    endcase
  end

`ifdef INSN_ENC_IMM_CHECK_EN
  // Sign-extension bits [26:16] must agree for the value to fit 17-bit signed.
  assign imm_bad = (fmt == FMT_I) &&
                   !((&bus.in_imm[TGT_W-1:IMM_W-1]) || !(|bus.in_imm[TGT_W-1:IMM_W-1]));
`else
  assign imm_bad = 1'b0;
`endif

  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && (fmt != FMT_BAD) && !imm_bad;
  assign done         = bus.imem_we && bus.imem_ready;

  assign bus.in_ready  = !fifo_full;
  assign bus.imem_we   = !fifo_empty;
  assign bus.imem_addr = wptr_q;
  assign bus.imem_data = fifo_empty ? '0 : fifo_head;
  assign illegal_kind  = ill_q;
  assign words_written = ww_q;

  insn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (enc_word),
    .pop       (done),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next write pointer (load beats increment), sticky flag and write count.
  always_comb begin
    wptr_d = wptr_q;
    if (load_addr)  wptr_d = load_value;
    else if (done)  wptr_d = wptr_q + ADDR_W'(1);
    ill_d = ill_q || (accept && (fmt == FMT_BAD));
    ww_d  = (done && (ww_q != 16'hFFFF)) ? ww_q + 16'd1 : ww_q;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= BASE_ADDR;
      ill_q  <= 1'b0;
      ww_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      ill_q  <= ill_d;
      ww_q   <= ww_d;
    end
  end

`ifdef INSN_ENC_IMM_CHECK_EN
  logic range_q, range_d;

  assign range_d       = range_q || (accept && imm_bad);
  assign imm_range_err = range_q;

  // Sticky out-of-range immediate flag.
  always_ff @(posedge clock) begin
    if (reset) range_q <= 1'b0;
    else       range_q <= range_d;
  end
`endif

endmodule
